decodificar_inmediato: RTL and testbench

DECODIFICAR_INMEDIATO -- requirements
Module: decodificar_inmediato

---
 rtl/decodificar_inmediato.sv | 118 +++++++++++
 tb/tb_decodificar_inmediato.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decodificar_inmediato.sv
// Two-stage RV32I immediate decoder: S1 captures the word and its format code, S2 builds the
// sign-extended immediate. Both stages use valid/ready handshakes and count delivered results.
module decodificar_inmediato #(
  parameter int ANCHO_CONT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           Instr,
  input  logic                  Instr_Valid,
  output logic                  Instr_Ready,
  output logic [31:0]           Inmediato,
  output logic [4:0]            Imm_Bajo,
  output logic [6:0]            Imm_Alto,
  output logic [2:0]            Tipo,
  output logic                  Error,
  output logic                  Salida_Valid,
  input  logic                  Salida_Ready,
  output logic [ANCHO_CONT-1:0] Contador
);

  typedef enum logic [2:0] {
    TIPO_R      = 3'd0,
    TIPO_I      = 3'd1,
    TIPO_S      = 3'd2,
    TIPO_B      = 3'd3,
    TIPO_U      = 3'd4,
    TIPO_J      = 3'd5,
    TIPO_ILEGAL = 3'd7
  } tipo_e;

  function automatic tipo_e decodificar(input logic [6:0] opcode);
    tipo_e t;
    case (opcode)
      7'b0110011:                         t = TIPO_R;
      7'b0010011, 7'b0000011, 7'b1100111: t = TIPO_I;
      7'b0100011:                         t = TIPO_S;
      7'b1100011:                         t = TIPO_B;
      7'b0110111, 7'b0010111:             t = TIPO_U;
      7'b1101111:                         t = TIPO_J;
      default:                            t = TIPO_ILEGAL;
    endcase
    return t;
  endfunction

  // The opcode is fully captured by the format code, so S1 keeps only bits [31:7].
  logic                  s1_valid_q;
  logic [31:7]           s1_instr_q;
  tipo_e                 s1_tipo_q;
  logic                  salida_valid_q;
  logic [31:0]           inmediato_q;
  tipo_e                 tipo_q;
  logic                  error_q;
  logic [ANCHO_CONT-1:0] contador_q;

  logic        s1_load;
  logic        s2_load;
  logic [31:0] inmediato_d;

  assign s2_load     = !salida_valid_q || Salida_Ready;
  assign s1_load     = !s1_valid_q || s2_load;
  assign Instr_Ready = s1_load && !reset;

  always_comb begin
    inmediato_d = 32'd0;
    case (s1_tipo_q)
      TIPO_I:  inmediato_d = {{20{s1_instr_q[31]}}, s1_instr_q[31:20]};
      TIPO_S:  inmediato_d = {{20{s1_instr_q[31]}}, s1_instr_q[31:25], s1_instr_q[11:7]};
      TIPO_B:  inmediato_d = {{19{s1_instr_q[31]}}, s1_instr_q[31], s1_instr_q[7],
                              s1_instr_q[30:25], s1_instr_q[11:8], 1'b0};
      TIPO_U:  inmediato_d = {s1_instr_q[31:12], 12'd0};
      TIPO_J:  inmediato_d = {{11{s1_instr_q[31]}}, s1_instr_q[31], s1_instr_q[19:12],
                              s1_instr_q[20], s1_instr_q[30:21], 1'b0};
      default: inmediato_d = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q     <= 1'b0;
      s1_instr_q     <= '0;
      s1_tipo_q      <= TIPO_R;
      salida_valid_q <= 1'b0;
      inmediato_q    <= 32'd0;
      tipo_q         <= TIPO_R;
      error_q        <= 1'b0;
      contador_q     <= '0;
    end else begin
      if (s1_load) begin
        s1_valid_q <= Instr_Valid;
        if (Instr_Valid) begin
          s1_instr_q <= Instr[31:7];
          s1_tipo_q  <= decodificar(Instr[6:0]);
        end
      end
      // An empty S1 still advances as a bubble; S2 data is only replaced by a real word.
      if (s2_load) begin
        salida_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          inmediato_q <= inmediato_d;
          tipo_q      <= s1_tipo_q;
          error_q     <= (s1_tipo_q == TIPO_ILEGAL);
        end
      end
      if (salida_valid_q && Salida_Ready) begin
        contador_q <= contador_q + 1'b1;
      end
    end
  end

  assign Salida_Valid = salida_valid_q;
  assign Inmediato    = inmediato_q;
  assign Imm_Bajo     = inmediato_q[4:0];
  assign Imm_Alto     = inmediato_q[11:5];
  assign Tipo         = tipo_q;
  assign Error        = error_q;
  assign Contador     = contador_q;

endmodule

// File: tb/tb_decodificar_inmediato.sv
// Directed bench for decodificar_inmediato: a table of decode vectors plus hand-written
// sequences for back-to-back flow, backpressure, mid-flight reset and counter wrap.
module tb_decodificar_inmediato;

  localparam int ANCHO_CONT = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [31:0]           Instr;
  logic                  Instr_Valid;
  logic                  Instr_Ready;
  logic [31:0]           Inmediato;
  logic [4:0]            Imm_Bajo;
  logic [6:0]            Imm_Alto;
  logic [2:0]            Tipo;
  logic                  Error;
  logic                  Salida_Valid;
  logic                  Salida_Ready;
  logic [ANCHO_CONT-1:0] Contador;

  decodificar_inmediato #(.ANCHO_CONT(ANCHO_CONT)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .Instr_Valid(Instr_Valid),
    .Instr_Ready(Instr_Ready), .Inmediato(Inmediato), .Imm_Bajo(Imm_Bajo),
    .Imm_Alto(Imm_Alto), .Tipo(Tipo), .Error(Error), .Salida_Valid(Salida_Valid),
    .Salida_Ready(Salida_Ready), .Contador(Contador)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  tipo;
    logic [31:0] imm;
    logic        err;
  } vec_t;

  vec_t vecs[11];

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic in_fire, out_fire;
  logic [2:0]  got_tipo[$];
  logic [31:0] got_imm[$];
  int          got_cyc[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Called just after a falling edge with inputs already driven; records both handshakes.
  task automatic tick();
    #1;
    in_fire  = Instr_Valid && Instr_Ready;
    out_fire = Salida_Valid && Salida_Ready;
    if (out_fire) begin
      got_tipo.push_back(Tipo);
      got_imm.push_back(Inmediato);
      got_cyc.push_back(cyc);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic clear_got();
    got_tipo.delete();
    got_imm.delete();
    got_cyc.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    Instr_Valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    clear_got();
  endtask

  task automatic stream(input int n);
    int sent;
    sent = 0;
    clear_got();
    Salida_Ready = 1'b1;
    Instr = 32'h05700093;
    for (int c = 0; c < n + 20 && got_imm.size() < n; c++) begin
      Instr_Valid = (sent < n);
      tick();
      if (in_fire) sent++;
    end
    Instr_Valid = 1'b0;
    chk("stream_count", got_imm.size(), n);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0x00000000, expected 0x00000001");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] bp_instr[3];
    logic [2:0]  bp_tipo[3];
    logic [31:0] bp_imm[3];
    int idx, sv_seen;

    vecs[0]  = '{32'hFE512E23, 3'd2, 32'hFFFFFFFC, 1'b0}; // sw x5,-4(x2)
    vecs[1]  = '{32'h05700093, 3'd1, 32'h00000057, 1'b0}; // addi, imm 87
    vecs[2]  = '{32'h123450B7, 3'd4, 32'h12345000, 1'b0}; // lui
    vecs[3]  = '{32'h0000007F, 3'd7, 32'h00000000, 1'b1}; // illegal opcode
    vecs[4]  = '{32'h003100B3, 3'd0, 32'h00000000, 1'b0}; // add, right after illegal
    vecs[5]  = '{32'hFE000EE3, 3'd3, 32'hFFFFFFFC, 1'b0}; // branch, -4
    vecs[6]  = '{32'h001000EF, 3'd5, 32'h00000800, 1'b0}; // jal +2048
    vecs[7]  = '{32'hFFDFF0EF, 3'd5, 32'hFFFFFFFC, 1'b0}; // jal -4
    vecs[8]  = '{32'h7FF02283, 3'd1, 32'h000007FF, 1'b0}; // lw, imm 2047
    vecs[9]  = '{32'h800080E7, 3'd1, 32'hFFFFF800, 1'b0}; // jalr, imm -2048
    vecs[10] = '{32'h00001297, 3'd4, 32'h00001000, 1'b0}; // auipc

    Instr = 32'd0;
    Instr_Valid = 1'b0;
    Salida_Ready = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    tick();
    tick();
    chk("rst_instr_ready", Instr_Ready, 1'b0);
    chk("rst_salida_valid", Salida_Valid, 1'b0);
    chk("rst_inmediato", Inmediato, 32'd0);
    chk("rst_bajo_alto", {Imm_Alto, Imm_Bajo}, 12'd0);
    chk("rst_tipo", Tipo, 3'd0);
    chk("rst_error", Error, 1'b0);
    chk("rst_contador", Contador, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", Instr_Ready, 1'b1);
    clear_got();

    foreach (vecs[i]) begin
      Salida_Ready = 1'b1;
      Instr = vecs[i].instr;
      Instr_Valid = 1'b1;
      tick();
      chk("vec_accept", in_fire, 1'b1);
      Instr_Valid = 1'b0;
      chk("vec_lat1_valid", Salida_Valid, 1'b0);
      tick();
      chk("vec_lat2_valid", Salida_Valid, 1'b1);
      chk("vec_tipo", Tipo, vecs[i].tipo);
      chk("vec_imm", Inmediato, vecs[i].imm);
      chk("vec_bajo", Imm_Bajo, vecs[i].imm[4:0]);
      chk("vec_alto", Imm_Alto, vecs[i].imm[11:5]);
      chk("vec_error", Error, vecs[i].err);
      $display("vec %0d instr=0x%08h tipo=%0d imm=0x%08h err=%0b", i, Instr, Tipo, Inmediato, Error);
    end
    tick();

    // Back-to-back: two words on consecutive edges emerge on consecutive edges.
    do_reset();
    Salida_Ready = 1'b1;
    Instr_Valid = 1'b1;
    Instr = 32'h05700093;
    tick();
    chk("b2b_accept0", in_fire, 1'b1);
    Instr = 32'h123450B7;
    tick();
    chk("b2b_accept1", in_fire, 1'b1);
    Instr_Valid = 1'b0;
    repeat (4) tick();
    chk("b2b_count", got_imm.size(), 2);
    if (got_imm.size() >= 2) begin
      chk("b2b_tipo0", got_tipo[0], 3'd1);
      chk("b2b_imm0", got_imm[0], 32'h00000057);
      chk("b2b_tipo1", got_tipo[1], 3'd4);
      chk("b2b_imm1", got_imm[1], 32'h12345000);
      chk("b2b_gap", got_cyc[1] - got_cyc[0], 1);
    end
    chk("b2b_contador", Contador, 2);
    $display("b2b outputs=%0d contador=%0d", got_imm.size(), Contador);

    // Backpressure: 5 stalled cycles with 3 words offered, then release.
    bp_instr = '{32'h05700093, 32'h123450B7, 32'hFE512E23};
    bp_tipo  = '{3'd1, 3'd4, 3'd2};
    bp_imm   = '{32'h00000057, 32'h12345000, 32'hFFFFFFFC};
    do_reset();
    Salida_Ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      Instr_Valid = 1'b1;
      Instr = bp_instr[idx];
      tick();
      if (in_fire && idx < 2) idx++;
      else if (in_fire) idx = 3;
    end
    chk("bp_accepted", idx, 2);
    chk("bp_ready_low", Instr_Ready, 1'b0);
    chk("bp_valid", Salida_Valid, 1'b1);
    chk("bp_hold_imm", Inmediato, 32'h00000057);
    chk("bp_hold_tipo", Tipo, 3'd1);
    tick();
    chk("bp_hold_imm2", Inmediato, 32'h00000057);
    chk("bp_hold_alto", Imm_Alto, 7'd2);
    Salida_Ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      Instr_Valid = (idx < 3);
      Instr = (idx < 3) ? bp_instr[idx] : 32'd0;
      tick();
      if (in_fire) idx++;
    end
    chk("bp_out_count", got_imm.size(), 3);
    for (int k = 0; k < 3 && k < got_imm.size(); k++) begin
      chk("bp_order_tipo", got_tipo[k], bp_tipo[k]);
      chk("bp_order_imm", got_imm[k], bp_imm[k]);
    end
    chk("bp_contador", Contador, 3);
    $display("bp accepted=%0d outputs=%0d contador=%0d", idx, got_imm.size(), Contador);

    // Reset one cycle after an accepted word discards it.
    do_reset();
    Salida_Ready = 1'b1;
    Instr_Valid = 1'b1;
    Instr = 32'h05700093;
    tick();
    chk("mid_rst_accept", in_fire, 1'b1);
    Instr_Valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("mid_rst_ready", Instr_Ready, 1'b0);
    reset = 1'b0;
    sv_seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (Salida_Valid) sv_seen++;
    end
    chk("mid_rst_no_output", sv_seen, 0);
    chk("mid_rst_contador", Contador, 0);
    $display("mid-reset valid_seen=%0d contador=%0d", sv_seen, Contador);

    // Counter wrap with a 4-bit counter.
    do_reset();
    stream(15);
    chk("wrap_full", Contador, 4'hF);
    stream(1);
    chk("wrap_zero", Contador, 4'h0);
    $display("wrap contador=%0d", Contador);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
